// File: rtl/integral_image_gen_if.sv
// Pixel-in / integral-image-buffer-out bundle for integral_image_gen.
// master drives pixels and frame start; slave is the generator.
interface integral_image_gen_if;
  logic        iStart;
  logic        iPixel_valid;
  logic [7:0]  iPixel;
  logic        oWrreq_IIB;
  logic [12:0] oAddr_IIB;
  logic [20:0] oData_to_IIB;
  logic        oBusy;
  logic        oDone;

  modport master (
    output iStart, iPixel_valid, iPixel,
    input  oWrreq_IIB, oAddr_IIB, oData_to_IIB, oBusy, oDone
  );

  modport slave (
    input  iStart, iPixel_valid, iPixel,
    output oWrreq_IIB, oAddr_IIB, oData_to_IIB, oBusy, oDone
  );
endinterface

// File: rtl/integral_image_gen.sv
// Streaming integral-image generator; optional IIG_RESTART_EN makes iStart in RUN abort and restart.
// Latency: write strobe/address/data registered, one cycle after the accepted pixel.
// Backpressure: none; every valid pixel in RUN is accepted, pixels in IDLE are dropped.
module integral_image_gen #(
  parameter int IMG_W = 80,
  parameter int IMG_H = 60
) (
  input logic                iClk,
  input logic                iReset_n,
  integral_image_gen_if.slave bus
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        clear;
  logic        last_px;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [12:0]   addr_cnt;
  logic [20:0]   rowsum;
  logic [20:0]   line_mem [IMG_W];

  logic [20:0] row_base, rowsum_nxt, line_prev, ii;

  logic        wr_q;
  logic [12:0] addr_q;
  logic [20:0] data_q;
  logic        done_q;

  assign last_px = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iStart) begin
          state_nxt = RUN;
          clear     = 1'b1;
        end
      end
      RUN: begin
`ifdef IIG_RESTART_EN
        if (bus.iStart) clear = 1'b1;
        else
`endif
        if (bus.iPixel_valid) begin
          accept = 1'b1;
          if (last_px) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // First column and first row mask stale accumulator / line contents.
  assign row_base   = (x == '0) ? 21'd0 : rowsum;
  assign rowsum_nxt = row_base + 21'(bus.iPixel);
  assign line_prev  = (y == '0) ? 21'd0 : line_mem[x];
  assign ii         = rowsum_nxt + line_prev;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      x        <= '0;
      y        <= '0;
      addr_cnt <= '0;
      rowsum   <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_q   <= accept;
      done_q <= accept && last_px;
      if (clear) begin
        x        <= '0;
        y        <= '0;
        addr_cnt <= '0;
        rowsum   <= '0;
      end else if (accept) begin
        rowsum   <= rowsum_nxt;
        addr_cnt <= addr_cnt + 13'd1;
        addr_q   <= addr_cnt;
        data_q   <= ii;
        if (x == XW'(IMG_W - 1)) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (accept) line_mem[x] <= ii;
  end

  assign bus.oWrreq_IIB   = wr_q;
  assign bus.oAddr_IIB    = addr_q;
  assign bus.oData_to_IIB = data_q;
  assign bus.oDone        = done_q;
  assign bus.oBusy        = (state == RUN);
endmodule
